// File: rtl/rc4_pkg.sv
// rc4_pkg: shared definitions for the RC4 pipeline (key scheduler and decrypt
// stage). Holds the S-RAM geometry, the secret key length and the key
// scheduling FSM state encoding.
package rc4_pkg;

  localparam int DATA_WIDTH = 8;   // S-RAM word; mod-256 sums rely on natural wrap
  localparam int ADDR_WIDTH = 8;   // 256-entry S-RAM
  localparam int KEY_LEN    = 3;   // secret key length in bytes

  // Width of the mod-KEY_LEN key byte index.
  localparam int KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    SI_ADDR,
    SI_WAIT,
    SI_CAP,
    SJ_ADDR,
    SJ_WAIT,
    SJ_CAP,
    WR_J,
    WR_I,
    DONE
  } ksa_state_t;

endpackage

// File: rtl/ksa_key_sel.sv
// ksa_key_sel: selects one byte of the latched secret key by a mod-KEY_LEN
// index. Byte 0 is the most significant byte of the key vector.
//
// Ports:
//   key      latched secret key, KEY_LEN bytes
//   idx      key byte index, 0 .. KEY_LEN-1
//   key_byte selected key byte
module ksa_key_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = rc4_pkg::KEY_LEN
) (
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [KIDX_W-1:0]      idx,
  output logic [7:0]             key_byte
);

  // Plain mux over the key bytes; the index is a running counter so no
  // modulo hardware is needed.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (idx == KIDX_W'(b)) begin
        key_byte = key[(KEY_BYTES-1-b)*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/s_key_scheduler.sv
// s_key_scheduler: RC4 key scheduling algorithm (KSA) driving an external
// scratchpad S-RAM. On start it latches the secret key, writes S[k]=k for all
// 256 entries, then performs 256 swap iterations of 8 cycles each. finish
// goes high once the S-RAM holds the shuffled array and stays high until
// reset.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-low reset
//   secret_key secret key, byte 0 in the top byte
//   start      begin init + shuffle (sampled in IDLE only)
//   finish     S-RAM holds the shuffled array
//   s_addr     S-RAM address
//   s_data     S-RAM write data
//   s_wren     S-RAM write enable
//   s_q        S-RAM read data, valid in the second cycle of an address
module s_key_scheduler
  import rc4_pkg::*;
#(
  parameter int DATA_WIDTH = rc4_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rc4_pkg::ADDR_WIDTH,
  parameter int KEY_LEN    = rc4_pkg::KEY_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_LEN*8-1:0]  secret_key,
  input  logic                  start,
  output logic                  finish,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_wren,
  input  logic [DATA_WIDTH-1:0] s_q
);

  ksa_state_t            state;
  logic [ADDR_WIDTH-1:0] i;
  logic [DATA_WIDTH-1:0] j;
  logic [DATA_WIDTH-1:0] si;
  logic [DATA_WIDTH-1:0] sj;
  logic [KEY_LEN*8-1:0]  key_q;
  logic [KIDX_W-1:0]     kidx;
  logic [7:0]            key_byte;
  logic [DATA_WIDTH-1:0] j_next;
  logic [KIDX_W-1:0]     kidx_next;

  ksa_key_sel #(
    .KEY_BYTES (KEY_LEN)
  ) u_key_sel (
    .key      (key_q),
    .idx      (kidx),
    .key_byte (key_byte)
  );

  // Sums truncate to the word width; this is the mod-256 of the algorithm.
  assign j_next    = j + s_q + key_byte;
  assign kidx_next = (kidx == KIDX_W'(KEY_LEN-1)) ? '0 : kidx + 1'b1;

  // Outputs are set on entry to the state that presents them, so every
  // port is a plain register. A write presented in a cycle lands at the
  // posedge that ends that cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      si     <= '0;
      sj     <= '0;
      key_q  <= '0;
      kidx   <= '0;
      finish <= 1'b0;
      s_wren <= 1'b0;
      s_addr <= '0;
      s_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key_q  <= secret_key;
            i      <= '0;
            j      <= '0;
            kidx   <= '0;
            s_addr <= '0;
            s_data <= '0;
            s_wren <= 1'b1;
            state  <= INIT;
          end
        end

        // One identity write per cycle; the write of address 255 is the
        // last INIT cycle, then i wraps to 0 for the shuffle.
        INIT: begin
          if (&i) begin
            i      <= '0;
            s_addr <= '0;
            s_wren <= 1'b0;
            state  <= SI_ADDR;
          end else begin
            i      <= i + 1'b1;
            s_addr <= i + 1'b1;
            s_data <= i + 1'b1;
          end
        end

        SI_ADDR: state <= SI_WAIT;
        SI_WAIT: state <= SI_CAP;

        SI_CAP: begin
          si     <= s_q;
          j      <= j_next;
          s_addr <= j_next;
          state  <= SJ_ADDR;
        end

        SJ_ADDR: state <= SJ_WAIT;
        SJ_WAIT: state <= SJ_CAP;

        SJ_CAP: begin
          sj     <= s_q;
          s_addr <= j;
          s_data <= si;
          s_wren <= 1'b1;
          state  <= WR_J;
        end

        // When i == j both writes hit one address with the value read
        // from it, so S is left unchanged.
        WR_J: begin
          s_addr <= i;
          s_data <= sj;
          state  <= WR_I;
        end

        WR_I: begin
          s_wren <= 1'b0;
          if (&i) begin
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            i      <= i + 1'b1;
            kidx   <= kidx_next;
            s_addr <= i + 1'b1;
            state  <= SI_ADDR;
          end
        end

        // Terminal until reset; start is ignored here.
        DONE: ;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s_key_scheduler.sv
// Bench for s_key_scheduler: S-RAM model with two-cycle read, a reference
// RC4 KSA in software, and a scoreboard whose expected final S array and
// finish cycle are queued at start and checked when finish rises.
module tb_s_key_scheduler;

  logic        clk;
  logic        rst;
  logic [23:0] secret_key;
  logic        start;
  logic        finish;
  logic [7:0]  s_addr;
  logic [7:0]  s_data;
  logic        s_wren;
  logic [7:0]  s_q;

  s_key_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .secret_key (secret_key),
    .start      (start),
    .finish     (finish),
    .s_addr     (s_addr),
    .s_data     (s_data),
    .s_wren     (s_wren),
    .s_q        (s_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // S-RAM: address registered once, data read from the array, so s_q
  // reflects an address from its second driven cycle onward.
  logic [7:0] mem [256];
  logic [7:0] a1;
  int         wr_cnt;

  initial begin
    wr_cnt = 0;
    a1     = '0;
    for (int k = 0; k < 256; k++) mem[k] = 8'hxx;
  end

  always @(posedge clk) begin
    if (s_wren) begin
      mem[s_addr] <= s_data;
      wr_cnt      <= wr_cnt + 1;
    end
    a1 <= s_addr;
  end

  assign s_q = mem[a1];

  int n_cmp;
  int n_err;
  int run_cyc;   // cycle 1 is the cycle right after the start-sampling edge

  logic [2047:0] exp_s_q [$];
  int            exp_cyc_q [$];

  task automatic chk(input string name, input bit ok, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [2047:0] ksa_model(input logic [23:0] key);
    logic [7:0]    s [256];
    logic [7:0]    j;
    logic [7:0]    t;
    logic [7:0]    kb;
    logic [2047:0] r;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      kb   = key[8*(2 - (i % 3)) +: 8];
      j    = j + s[i] + kb;
      t    = s[i];
      s[i] = s[j];
      s[j] = t;
    end
    for (int k = 0; k < 256; k++) r[8*k +: 8] = s[k];
    return r;
  endfunction

  // Scoreboard monitor: on each rising finish pop the expected run.
  initial begin : monitor
    logic          fin_prev;
    logic [2047:0] e_s;
    int            e_cyc;
    int            bad;
    fin_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (finish === 1'b1 && fin_prev !== 1'b1) begin
        if (exp_s_q.size() == 0) begin
          chk("unexpected_finish", 1'b0, 32'd1, 32'd0);
        end else begin
          e_s   = exp_s_q.pop_front();
          e_cyc = exp_cyc_q.pop_front();
          chk("finish_cycle", run_cyc == e_cyc, run_cyc, e_cyc);
          bad = -1;
          for (int k = 255; k >= 0; k--)
            if (mem[k] !== e_s[8*k +: 8]) bad = k;
          if (bad < 0)
            chk("final_S", 1'b1, 32'd0, 32'd0);
          else
            chk($sformatf("final_S[%0d]", bad), 1'b0, {24'd0, mem[bad]},
                {24'd0, e_s[8*bad +: 8]});
        end
      end
      fin_prev = finish;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic do_run(input logic [23:0] key, input bit hold, input bit toggle,
                        input bit chk_init, input bit chk_perm);
    int base;
    int after;
    int bad;
    int hist [256];
    do_reset();
    exp_s_q.push_back(ksa_model(key));
    exp_cyc_q.push_back(2305);
    @(negedge clk);
    secret_key = key;
    start      = 1'b1;
    base       = wr_cnt;
    @(posedge clk);
    #1;
    run_cyc = 1;
    if (!hold) start = 1'b0;
    while (finish !== 1'b1 && run_cyc < 3000) begin
      @(posedge clk);
      #1;
      run_cyc++;
      if (toggle && run_cyc == 500) secret_key = ~key ^ 24'h5A5A5A;
      if (chk_init && run_cyc == 257) begin
        bad = -1;
        for (int k = 255; k >= 0; k--) if (mem[k] !== 8'(k)) bad = k;
        chk("init_identity", bad < 0, bad, 32'hFFFFFFFF);
      end
    end
    chk("finish_timeout", finish === 1'b1, {31'd0, finish}, 32'd1);
    @(negedge clk);
    chk("write_count", (wr_cnt - base) == 768, wr_cnt - base, 32'd768);
    if (chk_perm) begin
      for (int k = 0; k < 256; k++) hist[k] = 0;
      for (int k = 0; k < 256; k++) hist[mem[k]]++;
      bad = -1;
      for (int k = 255; k >= 0; k--) if (hist[k] != 1) bad = k;
      chk("permutation", bad < 0, bad, 32'hFFFFFFFF);
    end
    if (hold) begin
      after = wr_cnt;
      repeat (20) @(posedge clk);
      #1;
      chk("done_finish_held", finish === 1'b1, {31'd0, finish}, 32'd1);
      chk("done_no_restart", wr_cnt == after, wr_cnt - after, 32'd0);
      start = 1'b0;
    end
  endtask

  // Start a run and pull reset during SJ_WAIT of iteration i=100
  // (SI_ADDR of iteration n is cycle 257+8n, SJ_WAIT four cycles later).
  task automatic abort_run(input logic [23:0] key);
    int base;
    do_reset();
    @(negedge clk);
    secret_key = key;
    start      = 1'b1;
    @(posedge clk);
    #1;
    run_cyc = 1;
    start   = 1'b0;
    while (run_cyc < 1061) begin
      @(posedge clk);
      #1;
      run_cyc++;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_finish", finish === 1'b0, {31'd0, finish}, 32'd0);
    chk("abort_wren", s_wren === 1'b0, {31'd0, s_wren}, 32'd0);
    chk("abort_addr", s_addr === 8'h00, {24'd0, s_addr}, 32'd0);
    chk("abort_data", s_data === 8'h00, {24'd0, s_data}, 32'd0);
    @(negedge clk);
    rst  = 1'b1;
    base = wr_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_idle_no_write", wr_cnt == base, wr_cnt - base, 32'd0);
  endtask

  initial begin : driver
    n_cmp      = 0;
    n_err      = 0;
    run_cyc    = 0;
    rst        = 1'b0;
    start      = 1'b0;
    secret_key = 24'h000000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_finish", finish === 1'b0, {31'd0, finish}, 32'd0);
    chk("rst_wren", s_wren === 1'b0, {31'd0, s_wren}, 32'd0);
    chk("rst_addr", s_addr === 8'h00, {24'd0, s_addr}, 32'd0);
    chk("rst_data", s_data === 8'h00, {24'd0, s_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_run(24'h000000, 1'b0, 1'b0, 1'b1, 1'b0);
    do_run(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    do_run(24'h000249, 1'b0, 1'b0, 1'b0, 1'b1);
    abort_run(24'h123456);
    do_run(24'h123456, 1'b0, 1'b0, 1'b0, 1'b1);
    do_run(24'hA5C3E1, 1'b1, 1'b1, 1'b0, 1'b0);

    chk("scoreboard_drained", exp_s_q.size() == 0, exp_s_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
